axi_mst_rd: RTL and testbench

AXI read master that converts a single-command request interface into one AXI read burst and consumes the returned R beats. It sits directly upstream of the AXI read slave: it drives the AR channel, sinks the R channel, forwards beats to a local consumer, and reports a per-burst completion status. Response codes, burst length and RLAST placement are checked on every burst. An optional checker compares RDATA against the slave's generated pattern.

---
 rtl/axi_mst_rd_pkg.sv | 60 ++++++
 rtl/axi_burst_addr_gen.sv | 56 +++++
 rtl/axi_mst_rd.sv | 163 ++++++++++++++++
 tb/tb_axi_mst_rd.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mst_rd_pkg.sv
// Shared AXI read definitions: channel width macros, burst/resp codes, FSM state type.
// Widths can be overridden by predefining the AXI_*_WIDTH macros.
`ifndef AXI_ID_WIDTH
`define AXI_ID_WIDTH 4
`endif
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_LEN_WIDTH
`define AXI_LEN_WIDTH 8
`endif
`ifndef AXI_SIZE_WIDTH
`define AXI_SIZE_WIDTH 3
`endif
`ifndef AXI_BURST_WIDTH
`define AXI_BURST_WIDTH 2
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 64
`endif
`ifndef AXI_RESP_WIDTH
`define AXI_RESP_WIDTH 2
`endif

package axi_mst_rd_pkg;
  localparam int ID_W    = `AXI_ID_WIDTH;
  localparam int ADDR_W  = `AXI_ADDR_WIDTH;
  localparam int LEN_W   = `AXI_LEN_WIDTH;
  localparam int SIZE_W  = `AXI_SIZE_WIDTH;
  localparam int BURST_W = `AXI_BURST_WIDTH;
  localparam int DATA_W  = `AXI_DATA_WIDTH;
  localparam int RESP_W  = `AXI_RESP_WIDTH;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Resp codes are ordered by severity, so the worst is the numeric max.
  function automatic logic [RESP_W-1:0] resp_max(input logic [RESP_W-1:0] a,
                                                 input logic [RESP_W-1:0] b);
    return (b > a) ? b : a;
  endfunction
endpackage

// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI burst address generator (FIXED / INCR / WRAP); reserved burst holds the address.
module axi_burst_addr_gen
  import axi_mst_rd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [LEN_W-1:0]  i_len,
  input  logic [SIZE_W-1:0] i_size,
  input  logic [BURST_W-1:0] i_burst,
  output logic [ADDR_W-1:0] o_addr
);
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_nbytes;
  logic [ADDR_W-1:0] w_wrap_bytes;
  logic [ADDR_W-1:0] w_boundary;
  logic [ADDR_W-1:0] w_incr;
  logic [ADDR_W-1:0] w_next;

  // Next-address computation for the current burst type.
  always_comb begin
    w_nbytes     = ONE << i_size;
    w_wrap_bytes = w_nbytes * ({{(ADDR_W-LEN_W){1'b0}}, i_len} + ONE);
    w_boundary   = r_addr & ~(w_wrap_bytes - ONE);
    w_incr       = r_addr + w_nbytes;
    w_next       = r_addr;
    case (i_burst)
      BURST_INCR: w_next = w_incr;
      BURST_WRAP: begin
        if (w_incr == (w_boundary + w_wrap_bytes)) begin
          w_next = w_boundary;
        end else begin
          w_next = w_incr;
        end
      end
      default:    w_next = r_addr;
    endcase
  end

  // Address register: loaded at command accept, advanced per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr <= {ADDR_W{1'b0}};
    end else if (i_load) begin
      r_addr <= i_start_addr;
    end else if (i_step) begin
      r_addr <= w_next;
    end
  end

  assign o_addr = r_addr;
endmodule

// File: rtl/axi_mst_rd.sv
// AXI read master: one command -> one AR burst, R beats forwarded to a consumer, per-burst status.
// Optional RDATA pattern checker enabled by defining AXI_MST_RD_CHECK_EN.
module axi_mst_rd
  import axi_mst_rd_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [ID_W-1:0]          i_cmd_id,
  input  logic [ADDR_W-1:0]        i_cmd_addr,
  input  logic [LEN_W-1:0]         i_cmd_len,
  input  logic [SIZE_W-1:0]        i_cmd_size,
  input  logic [BURST_W-1:0]       i_cmd_burst,
  output logic [ID_W-1:0]          o_axi_mst_arid,
  output logic [ADDR_W-1:0]        o_axi_mst_araddr,
  output logic [LEN_W-1:0]         o_axi_mst_arlen,
  output logic [SIZE_W-1:0]        o_axi_mst_arsize,
  output logic [BURST_W-1:0]       o_axi_mst_arburst,
  output logic                     o_axi_mst_arvalid,
  input  logic                     i_axi_mst_arready,
  input  logic [DATA_W-1:0]        i_axi_mst_rdata,
  input  logic [RESP_W-1:0]        i_axi_mst_rresp,
  input  logic                     i_axi_mst_rlast,
  input  logic                     i_axi_mst_rvalid,
  output logic                     o_axi_mst_rready,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [DATA_W-1:0]        o_out_data,
  output logic                     o_out_last,
  output logic                     o_done_valid,
  output logic [RESP_W-1:0]        o_done_resp,
  output logic                     o_done_proto_err,
  output logic [ERR_CNT_WIDTH-1:0] o_chk_err_cnt
);
  state_e             r_state;
  state_e             w_next_state;
  logic [ID_W-1:0]    r_id;
  logic [ADDR_W-1:0]  r_addr;
  logic [LEN_W-1:0]   r_len;
  logic [SIZE_W-1:0]  r_size;
  logic [BURST_W-1:0] r_burst;
  logic [LEN_W-1:0]   r_cnt;
  logic [RESP_W-1:0]  r_resp;
  logic               r_proto;
  logic               w_in_data;
  logic               w_cmd_fire;
  logic               w_beat;
  logic               w_at_len;
  logic               w_end;

  assign w_in_data  = (r_state == ST_DATA);
  assign w_cmd_fire = (r_state == ST_IDLE) & i_cmd_valid;
  assign w_beat     = w_in_data & i_axi_mst_rvalid & i_out_ready;
  assign w_at_len   = (r_cnt == r_len);
  // A missing RLAST still ends the burst at beat cmd_len, so r_cnt never wraps.
  assign w_end      = w_beat & (i_axi_mst_rlast | w_at_len);

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_cmd_valid) w_next_state = ST_ADDR;
        else             w_next_state = ST_IDLE;
      end
      ST_ADDR: begin
        if (i_axi_mst_arready) w_next_state = ST_DATA;
        else                   w_next_state = ST_ADDR;
      end
      ST_DATA: begin
        if (w_end) w_next_state = ST_DONE;
        else       w_next_state = ST_DATA;
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State, latched command and per-burst status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_id    <= {ID_W{1'b0}};
      r_addr  <= {ADDR_W{1'b0}};
      r_len   <= {LEN_W{1'b0}};
      r_size  <= {SIZE_W{1'b0}};
      r_burst <= {BURST_W{1'b0}};
      r_cnt   <= {LEN_W{1'b0}};
      r_resp  <= {RESP_W{1'b0}};
      r_proto <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_cmd_fire) begin
        r_id    <= i_cmd_id;
        r_addr  <= i_cmd_addr;
        r_len   <= i_cmd_len;
        r_size  <= i_cmd_size;
        r_burst <= i_cmd_burst;
        r_cnt   <= {LEN_W{1'b0}};
        r_resp  <= {RESP_W{1'b0}};
        r_proto <= 1'b0;
      end else if (w_beat) begin
        r_cnt   <= r_cnt + {{(LEN_W-1){1'b0}}, 1'b1};
        r_resp  <= resp_max(r_resp, i_axi_mst_rresp);
        r_proto <= r_proto | (i_axi_mst_rlast ^ w_at_len);
      end
    end
  end

  // Gated by rst so the handshake drops the moment reset is applied.
  assign o_cmd_ready       = (r_state == ST_IDLE) & ~rst;
  assign o_axi_mst_arvalid = (r_state == ST_ADDR);
  assign o_axi_mst_arid    = r_id;
  assign o_axi_mst_araddr  = r_addr;
  assign o_axi_mst_arlen   = r_len;
  assign o_axi_mst_arsize  = r_size;
  assign o_axi_mst_arburst = r_burst;
  assign o_axi_mst_rready  = w_in_data & i_out_ready;
  assign o_out_valid       = w_in_data & i_axi_mst_rvalid;
  assign o_out_data        = w_in_data ? i_axi_mst_rdata : {DATA_W{1'b0}};
  assign o_out_last        = w_in_data & i_axi_mst_rlast;
  assign o_done_valid      = (r_state == ST_DONE);
  assign o_done_resp       = r_resp;
  assign o_done_proto_err  = r_proto;

`ifdef AXI_MST_RD_CHECK_EN
  logic [ADDR_W-1:0]        w_exp_addr;
  logic [DATA_W-1:0]        w_exp_data;
  logic [ERR_CNT_WIDTH-1:0] r_chk_cnt;

  axi_burst_addr_gen u_addr_gen (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_cmd_fire),
    .i_step       (w_beat),
    .i_start_addr (i_cmd_addr),
    .i_len        (r_len),
    .i_size       (r_size),
    .i_burst      (r_burst),
    .o_addr       (w_exp_addr)
  );

  assign w_exp_data = {{(DATA_W-ID_W-ADDR_W){1'b0}}, r_id, w_exp_addr};

  // Saturating mismatch counter, cleared at command accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_cnt <= {ERR_CNT_WIDTH{1'b0}};
    end else if (w_cmd_fire) begin
      r_chk_cnt <= {ERR_CNT_WIDTH{1'b0}};
    end else if (w_beat && (i_axi_mst_rdata != w_exp_data) && (r_chk_cnt != {ERR_CNT_WIDTH{1'b1}})) begin
      r_chk_cnt <= r_chk_cnt + {{(ERR_CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign o_chk_err_cnt = r_chk_cnt;
`else
  assign o_chk_err_cnt = {ERR_CNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_axi_mst_rd.sv
// Scoreboard bench for axi_mst_rd: stimulus pushes expected beats/status, a monitor pops and compares.
module tb_axi_mst_rd;
  import axi_mst_rd_pkg::*;

`ifdef AXI_MST_RD_CHECK_EN
  localparam logic [7:0] CHK_CORRUPT = 8'd1;
`else
  localparam logic [7:0] CHK_CORRUPT = 8'd0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_cmd_valid = 1'b0;
  logic              o_cmd_ready;
  logic [ID_W-1:0]   i_cmd_id = '0;
  logic [ADDR_W-1:0] i_cmd_addr = '0;
  logic [LEN_W-1:0]  i_cmd_len = '0;
  logic [SIZE_W-1:0] i_cmd_size = '0;
  logic [BURST_W-1:0] i_cmd_burst = '0;
  logic [ID_W-1:0]   o_arid;
  logic [ADDR_W-1:0] o_araddr;
  logic [LEN_W-1:0]  o_arlen;
  logic [SIZE_W-1:0] o_arsize;
  logic [BURST_W-1:0] o_arburst;
  logic              o_arvalid;
  logic              i_arready = 1'b0;
  logic [DATA_W-1:0] i_rdata = '0;
  logic [RESP_W-1:0] i_rresp = '0;
  logic              i_rlast = 1'b0;
  logic              i_rvalid = 1'b0;
  logic              o_rready;
  logic              o_out_valid;
  logic              i_out_ready = 1'b1;
  logic [DATA_W-1:0] o_out_data;
  logic              o_out_last;
  logic              o_done_valid;
  logic [RESP_W-1:0] o_done_resp;
  logic              o_done_proto_err;
  logic [7:0]        o_chk_err_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [64:0] exp_beats[$];
  logic [10:0] exp_done[$];
  logic [31:0] exp_addr [8];

  axi_mst_rd #(.ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_id(i_cmd_id), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_cmd_size(i_cmd_size), .i_cmd_burst(i_cmd_burst),
    .o_axi_mst_arid(o_arid), .o_axi_mst_araddr(o_araddr), .o_axi_mst_arlen(o_arlen),
    .o_axi_mst_arsize(o_arsize), .o_axi_mst_arburst(o_arburst),
    .o_axi_mst_arvalid(o_arvalid), .i_axi_mst_arready(i_arready),
    .i_axi_mst_rdata(i_rdata), .i_axi_mst_rresp(i_rresp), .i_axi_mst_rlast(i_rlast),
    .i_axi_mst_rvalid(i_rvalid), .o_axi_mst_rready(o_rready),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_data(o_out_data),
    .o_out_last(o_out_last), .o_done_valid(o_done_valid), .o_done_resp(o_done_resp),
    .o_done_proto_err(o_done_proto_err), .o_chk_err_cnt(o_chk_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected beats and completion status whenever the DUT presents them.
  always @(negedge clk) begin
    logic [64:0] eb;
    logic [10:0] ed;
    if (!rst) begin
      if (o_out_valid && i_out_ready) begin
        if (exp_beats.size() == 0) begin
          check("beat_unexpected", {63'd0, o_out_valid}, 64'd0);
        end else begin
          eb = exp_beats.pop_front();
          check("beat_data", o_out_data, eb[64:1]);
          check("beat_last", {63'd0, o_out_last}, {63'd0, eb[0]});
        end
      end
      if (o_done_valid) begin
        if (exp_done.size() == 0) begin
          check("done_unexpected", {63'd0, o_done_valid}, 64'd0);
        end else begin
          ed = exp_done.pop_front();
          check("done_resp", {62'd0, o_done_resp}, {62'd0, ed[10:9]});
          check("done_proto", {63'd0, o_done_proto_err}, {63'd0, ed[8]});
          check("done_chk", {56'd0, o_chk_err_cnt}, {56'd0, ed[7:0]});
        end
      end
    end
  end

  task automatic issue_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    int t;
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_id = id; i_cmd_addr = addr;
    i_cmd_len = len; i_cmd_size = size; i_cmd_burst = burst;
    t = 0;
    while (!o_cmd_ready && t < 20) begin @(negedge clk); t++; end
    check("cmd_ready_timeout", {63'd0, o_cmd_ready}, 64'd1);
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    check("ar_latency", {63'd0, o_arvalid}, 64'd1);
    check("arid", {60'd0, o_arid}, {60'd0, id});
    check("araddr", {32'd0, o_araddr}, {32'd0, addr});
    check("arlen", {56'd0, o_arlen}, {56'd0, len});
    check("arsize", {61'd0, o_arsize}, {61'd0, size});
    check("arburst", {62'd0, o_arburst}, {62'd0, burst});
    // R beat offered before the AR handshake must be ignored.
    i_rvalid = 1'b1; i_rdata = {28'h0, id, exp_addr[0]}; i_rlast = 1'b0; i_rresp = RESP_OKAY;
    #1;
    check("rready_pre_ar", {63'd0, o_rready}, 64'd0);
    check("out_valid_pre_ar", {63'd0, o_out_valid}, 64'd0);
    @(negedge clk);
    check("ar_hold", {63'd0, o_arvalid}, 64'd1);
    i_arready = 1'b1;
    @(posedge clk); #1;
    i_arready = 1'b0;
    check("ar_drop", {63'd0, o_arvalid}, 64'd0);
  endtask

  task automatic drive_beat(input logic [3:0] id, input int b, input int last_at, input int bad_beat,
                            input logic [1:0] bad_resp, input int corrupt_beat);
    logic [63:0] d;
    d = {28'h0, id, exp_addr[b]};
    if (b == corrupt_beat) d = d ^ 64'h0000_0000_0000_0100;
    i_rvalid = 1'b1;
    i_rdata  = d;
    i_rresp  = (b == bad_beat) ? bad_resp : RESP_OKAY;
    i_rlast  = (b == last_at);
    exp_beats.push_back({d, (b == last_at)});
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int n_drive, input int last_at, input int bad_beat,
                           input logic [1:0] bad_resp, input int corrupt_beat, input int stall_beat,
                           input logic [1:0] exp_resp, input logic exp_proto, input logic [7:0] exp_chk);
    int t;
    exp_done.push_back({exp_resp, exp_proto, exp_chk});
    issue_cmd(id, addr, len, size, burst);
    for (int b = 0; b < n_drive; b++) begin
      drive_beat(id, b, last_at, bad_beat, bad_resp, corrupt_beat);
      if (b == stall_beat) begin
        i_out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_rready", {63'd0, o_rready}, 64'd0);
        end
        i_out_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    i_rvalid = 1'b0; i_rlast = 1'b0;
    t = 0;
    while (exp_done.size() != 0 && t < 50) begin @(negedge clk); #2; t++; end
    check("done_timeout", exp_done.size(), 64'd0);
    check("beats_consumed", exp_beats.size(), 64'd0);
    @(negedge clk); #1;
    check("done_one_cycle", {63'd0, o_done_valid}, 64'd0);
    check("back_to_idle", {63'd0, o_cmd_ready}, 64'd1);
  endtask

  initial begin
    #2;
    check("rst_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
    check("rst_arvalid", {63'd0, o_arvalid}, 64'd0);
    check("rst_done", {63'd0, o_done_valid}, 64'd0);
    check("rst_status", {53'd0, o_done_resp, o_done_proto_err, o_chk_err_cnt}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_after_rst", {63'd0, o_cmd_ready}, 64'd1);

    // INCR, clean OKAY burst.
    exp_addr = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(4'h3, 32'h100, 8'd3, 3'd2, BURST_INCR, 4, 3, -1, RESP_OKAY, -1, -1, RESP_OKAY, 1'b0, 8'd0);

    // WRAP 0x38 over a 32-byte window.
    exp_addr = '{32'h38, 32'h20, 32'h28, 32'h30, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(4'h5, 32'h38, 8'd3, 3'd3, BURST_WRAP, 4, 3, -1, RESP_OKAY, -1, -1, RESP_OKAY, 1'b0, 8'd0);
    run_burst(4'h5, 32'h38, 8'd3, 3'd3, BURST_WRAP, 4, 3, -1, RESP_OKAY, 1, -1, RESP_OKAY, 1'b0, CHK_CORRUPT);

    // SLVERR on last beat.
    exp_addr = '{32'h200, 32'h204, 32'h208, 32'h20C, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(4'hF, 32'h200, 8'd3, 3'd2, BURST_INCR, 4, 3, 3, RESP_SLVERR, -1, -1, RESP_SLVERR, 1'b0, 8'd0);

    // Early RLAST on beat 1 of a 4-beat burst.
    exp_addr = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(4'h1, 32'h40, 8'd3, 3'd2, BURST_INCR, 2, 1, -1, RESP_OKAY, -1, -1, RESP_OKAY, 1'b1, 8'd0);

    // Consumer back-pressure for 5 cycles on beat 2 of 6.
    exp_addr = '{32'h80, 32'h84, 32'h88, 32'h8C, 32'h90, 32'h94, 32'h0, 32'h0};
    run_burst(4'h2, 32'h80, 8'd5, 3'd2, BURST_INCR, 6, 5, -1, RESP_OKAY, -1, 2, RESP_OKAY, 1'b0, 8'd0);

    // Missing RLAST, DECERR on first beat.
    exp_addr = '{32'h500, 32'h504, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(4'h7, 32'h500, 8'd1, 3'd2, BURST_INCR, 2, -1, 0, RESP_DECERR, -1, -1, RESP_DECERR, 1'b1, 8'd0);

    // Reserved burst type is forwarded; address holds.
    exp_addr = '{32'h300, 32'h300, 32'h300, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(4'h9, 32'h300, 8'd2, 3'd2, BURST_RSVD, 3, 2, -1, RESP_OKAY, -1, -1, RESP_OKAY, 1'b0, 8'd0);

    // Reset asserted in the DATA phase.
    exp_addr = '{32'h400, 32'h404, 32'h408, 32'h40C, 32'h0, 32'h0, 32'h0, 32'h0};
    issue_cmd(4'h6, 32'h400, 8'd3, 3'd2, BURST_INCR);
    drive_beat(4'h6, 0, 3, -1, RESP_OKAY, -1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_arvalid", {63'd0, o_arvalid}, 64'd0);
    check("midrst_rready", {63'd0, o_rready}, 64'd0);
    check("midrst_out_valid", {63'd0, o_out_valid}, 64'd0);
    check("midrst_out_data", o_out_data, 64'd0);
    check("midrst_done", {63'd0, o_done_valid}, 64'd0);
    check("midrst_cmd_ready", {63'd0, o_cmd_ready}, 64'd0);
    i_rvalid = 1'b0;
    check("midrst_beats", exp_beats.size(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_idle", {63'd0, o_cmd_ready}, 64'd1);
    check("midrst_status", {53'd0, o_done_resp, o_done_proto_err, o_chk_err_cnt}, 64'd0);

    exp_addr = '{32'h600, 32'h604, 32'h608, 32'h60C, 32'h0, 32'h0, 32'h0, 32'h0};
    run_burst(4'hA, 32'h600, 8'd3, 3'd2, BURST_INCR, 4, 3, -1, RESP_OKAY, -1, -1, RESP_OKAY, 1'b0, 8'd0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
